// File: rtl/temporal_pkg.sv
// rtl/temporal_pkg.sv - shared defaults and types for the temporal encoder
package temporal_pkg;

  localparam int GAMMA_CYCLE_WIDTH_DEF = 16;
  localparam int PULSE_WIDTH_DEF       = 8;
  localparam int TW_DEF                = $clog2(GAMMA_CYCLE_WIDTH_DEF);

  typedef logic [TW_DEF-1:0] spike_time_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } enc_state_t;

endpackage

// File: rtl/temporal_pulse_gen.sv
// rtl/temporal_pulse_gen.sv - one channel's registered pulse-width spike bit
module temporal_pulse_gen #(
  parameter int TW          = 4,
  parameter int PULSE_WIDTH = 8
) (
  input  logic          aclk,
  input  logic          grst_n,
  input  logic [TW-1:0] k,
  input  logic [TW-1:0] t_i,
  input  logic          mask_i,
  input  logic          range_ok_i,
  output logic          spike_o
);

  // One extra bit so t_i+PULSE_WIDTH-1 never wraps
  logic [TW:0] k_w;
  logic [TW:0] lo;
  logic [TW:0] hi;

  assign k_w = {1'b0, k};
  assign lo  = {1'b0, t_i};
  assign hi  = lo + (TW+1)'(PULSE_WIDTH - 1);

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      spike_o <= 1'b0;
    end else begin
      spike_o <= mask_i && range_ok_i && (k_w >= lo) && (k_w <= hi);
    end
  end

endmodule

// File: rtl/temporal_encoder.sv
// rtl/temporal_encoder.sv - binary spike times to gamma-aligned pulse-width code
module temporal_encoder
  import temporal_pkg::*;
#(
  parameter int GAMMA_CYCLE_WIDTH = GAMMA_CYCLE_WIDTH_DEF,
  parameter int PULSE_WIDTH       = PULSE_WIDTH_DEF,
  parameter int N_CH              = 2,
  parameter int TW                = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic               aclk,
  input  logic               grst_n,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_CH*TW-1:0] in_time,
  input  logic [N_CH-1:0]    in_mask,
  output logic               gamma_rst_o,
  output logic [N_CH-1:0]    spike_o,
  output logic               busy_o,
  output logic               underrun_o,
  output logic               range_err_o
);

  if (PULSE_WIDTH >= GAMMA_CYCLE_WIDTH) begin : g_size_check
    $error("PULSE_WIDTH must be less than GAMMA_CYCLE_WIDTH");
  end

  localparam logic [TW-1:0] K_LAST = TW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [TW:0]   T_MAX  = (TW+1)'(GAMMA_CYCLE_WIDTH - PULSE_WIDTH);

  enc_state_t         state, state_nxt;
  logic [TW-1:0]      k, k_nxt;
  logic               run_nxt;
  logic               boundary;
  logic               xfer;
  logic [N_CH-1:0]    in_ok;

  logic               pend_valid;
  logic [N_CH*TW-1:0] pend_time;
  logic [N_CH-1:0]    pend_mask;
  logic [N_CH-1:0]    pend_ok;

  logic [N_CH*TW-1:0] act_time, act_time_nxt;
  logic [N_CH-1:0]    act_mask, act_mask_nxt;
  logic [N_CH-1:0]    act_ok, act_ok_nxt;

  assign in_ready = !pend_valid;
  assign busy_o   = (state == RUN);
  assign xfer     = in_valid && in_ready;

  // Legal times keep the pulse clear of gamma_rst and inside the cycle
  always_comb begin
    in_ok = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ok[i] = ({1'b0, in_time[i*TW +: TW]} >= (TW+1)'(1)) &&
                 ({1'b0, in_time[i*TW +: TW]} <= T_MAX);
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    run_nxt   = 1'b0;
    boundary  = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = RUN;
          k_nxt     = '0;
          run_nxt   = 1'b1;
          boundary  = 1'b1;
        end
      end
      RUN: begin
        run_nxt = 1'b1;
        if (k == K_LAST) begin
          k_nxt = '0;
          if (en) begin
            boundary = 1'b1;
          end else begin
            state_nxt = IDLE;
            run_nxt   = 1'b0;
          end
        end else begin
          k_nxt = k + TW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    act_time_nxt = act_time;
    act_mask_nxt = act_mask;
    act_ok_nxt   = act_ok;
    if (boundary) begin
      if (xfer) begin
        act_time_nxt = in_time;
        act_mask_nxt = in_mask;
        act_ok_nxt   = in_ok;
      end else if (pend_valid) begin
        act_time_nxt = pend_time;
        act_mask_nxt = pend_mask;
        act_ok_nxt   = pend_ok;
      end else begin
        act_mask_nxt = '0;
        act_ok_nxt   = '0;
      end
    end
  end

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      state       <= IDLE;
      k           <= '0;
      pend_valid  <= 1'b0;
      pend_time   <= '0;
      pend_mask   <= '0;
      pend_ok     <= '0;
      act_time    <= '0;
      act_mask    <= '0;
      act_ok      <= '0;
      gamma_rst_o <= 1'b0;
      underrun_o  <= 1'b0;
      range_err_o <= 1'b0;
    end else begin
      state    <= state_nxt;
      k        <= k_nxt;
      act_time <= act_time_nxt;
      act_mask <= act_mask_nxt;
      act_ok   <= act_ok_nxt;
      // A transfer on a boundary edge bypasses pending straight into active
      if (xfer && !boundary) begin
        pend_valid <= 1'b1;
        pend_time  <= in_time;
        pend_mask  <= in_mask;
        pend_ok    <= in_ok;
      end else if (boundary && pend_valid) begin
        pend_valid <= 1'b0;
      end
      gamma_rst_o <= run_nxt && (k_nxt == '0);
      underrun_o  <= boundary && !(xfer || pend_valid);
      range_err_o <= xfer && |(in_mask & ~in_ok);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    temporal_pulse_gen #(
      .TW          (TW),
      .PULSE_WIDTH (PULSE_WIDTH)
    ) u_pulse_gen (
      .aclk       (aclk),
      .grst_n     (grst_n),
      .k          (k_nxt),
      .t_i        (act_time_nxt[i*TW +: TW]),
      .mask_i     (act_mask_nxt[i] && run_nxt),
      .range_ok_i (act_ok_nxt[i]),
      .spike_o    (spike_o[i])
    );
  end

endmodule

// File: tb/tb_temporal_encoder.sv
// tb/tb_temporal_encoder.sv - randomized self-checking bench for temporal_encoder
module tb_temporal_encoder;

  localparam int G    = 16;
  localparam int PW   = 8;
  localparam int N_CH = 2;
  localparam int TW   = 4;

  typedef struct packed {
    logic [3:0] tb;
    logic [3:0] ta;
    logic [1:0] mask;
  } txn_t;

  logic              aclk = 1'b0;
  logic              grst_n = 1'b0;
  logic              en = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N_CH*TW-1:0] in_time = '0;
  logic [N_CH-1:0]   in_mask = '0;
  logic              gamma_rst_o;
  logic [N_CH-1:0]   spike_o;
  logic              busy_o;
  logic              underrun_o;
  logic              range_err_o;

  int n_chk = 0;
  int n_fail = 0;
  int rerr_cnt = 0;
  txn_t txq[$];

  temporal_encoder dut (
    .aclk        (aclk),
    .grst_n      (grst_n),
    .en          (en),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_time     (in_time),
    .in_mask     (in_mask),
    .gamma_rst_o (gamma_rst_o),
    .spike_o     (spike_o),
    .busy_o      (busy_o),
    .underrun_o  (underrun_o),
    .range_err_o (range_err_o)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) if (range_err_o === 1'b1) rerr_cnt++;

  function automatic bit legal(input int t);
    return (t >= 1) && (t <= G - PW);
  endfunction

  function automatic logic [1:0] exp_spk(input txn_t x, input int k);
    logic [1:0] r;
    int tt;
    for (int ch = 0; ch < 2; ch++) begin
      tt = (ch == 0) ? int'(x.ta) : int'(x.tb);
      r[ch] = x.mask[ch] && legal(tt) && (k >= tt) && (k <= tt + PW - 1);
    end
    return r;
  endfunction

  function automatic bit is_bad(input txn_t x);
    return (x.mask[0] && !legal(int'(x.ta))) || (x.mask[1] && !legal(int'(x.tb)));
  endfunction

  task automatic present(input txn_t x);
    in_time  = {x.tb, x.ta};
    in_mask  = x.mask;
    in_valid = 1'b1;
  endtask

  task automatic run_stream(input int ngam);
    int n;
    int rerr0;
    int exp_err;
    n = txq.size();
    rerr0 = rerr_cnt;
    exp_err = 0;
    foreach (txq[i]) if (is_bad(txq[i])) exp_err++;
    if (n > 0) begin
      present(txq[0]);
      @(posedge aclk);
      #1;
      in_valid = 1'b0;
    end else begin
      @(posedge aclk);
      #1;
    end
    en = 1'b1;
    fork
      begin
        for (int i = 1; i < n; i++) begin
          bit done;
          bit rdy;
          done = 1'b0;
          present(txq[i]);
          for (int w = 0; w < 4 * G && !done; w++) begin
            @(negedge aclk);
            rdy = in_ready;
            @(posedge aclk);
            done = rdy;
          end
          #1;
          n_chk++;
          if (!done) begin
            n_fail++;
            $display("FAIL handshake txn %0d: transfer got 0 want 1 within budget", i);
          end
        end
        in_valid = 1'b0;
      end
      begin
        @(posedge aclk);
        for (int c = 0; c < ngam * G; c++) begin
          int k;
          int j;
          logic [1:0] es;
          logic eu;
          logic er;
          k = c % G;
          j = c / G;
          @(negedge aclk);
          if (j < n) begin
            es = exp_spk(txq[j], k);
            eu = 1'b0;
          end else begin
            es = 2'b00;
            eu = (k == 0);
          end
          er = (k == 0) ? 1'b1 : !(j + 1 < n);
          n_chk += 5;
          if (spike_o !== es) begin
            n_fail++;
            $display("FAIL stream_spike g=%0d k=%0d got %b want %b", j, k, spike_o, es);
          end
          if (gamma_rst_o !== (k == 0)) begin
            n_fail++;
            $display("FAIL stream_gamma_rst g=%0d k=%0d got %b want %b", j, k, gamma_rst_o, k == 0);
          end
          if (underrun_o !== eu) begin
            n_fail++;
            $display("FAIL stream_underrun g=%0d k=%0d got %b want %b", j, k, underrun_o, eu);
          end
          if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_busy g=%0d k=%0d got %b want 1", j, k, busy_o);
          end
          if (in_ready !== er) begin
            n_fail++;
            $display("FAIL stream_in_ready g=%0d k=%0d got %b want %b", j, k, in_ready, er);
          end
          if (c == ngam * G - 1) en = 1'b0;
        end
      end
    join
    @(negedge aclk);
    n_chk += 3;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_end_busy got %b want 0", busy_o);
    end
    if ({spike_o, gamma_rst_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL stream_end_quiet got %b want 000", {spike_o, gamma_rst_o});
    end
    if (rerr_cnt - rerr0 !== exp_err) begin
      n_fail++;
      $display("FAIL stream_range_err_count got %0d want %0d", rerr_cnt - rerr0, exp_err);
    end
    txq.delete();
  endtask

  task automatic test_reset();
    grst_n = 1'b0;
    en = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge aclk);
    n_chk += 2;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    if ({spike_o, gamma_rst_o, busy_o, underrun_o, range_err_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b want 000000", {spike_o, gamma_rst_o, busy_o, underrun_o, range_err_o});
    end
    grst_n = 1'b1;
    repeat (2) @(negedge aclk);
    n_chk += 2;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_in_ready got %b want 1", in_ready);
    end
    if ({spike_o, gamma_rst_o, busy_o, underrun_o, range_err_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle got %b want 000000", {spike_o, gamma_rst_o, busy_o, underrun_o, range_err_o});
    end
  endtask

  task automatic test_underrun();
    run_stream(3);
  endtask

  task automatic test_pair();
    txq.push_back(txn_t'{tb: 4'd4, ta: 4'd2, mask: 2'b11});
    run_stream(2);
  endtask

  task automatic test_back_to_back();
    txq.push_back(txn_t'{tb: 4'd2, ta: 4'd4, mask: 2'b11});
    txq.push_back(txn_t'{tb: 4'd3, ta: 4'd3, mask: 2'b11});
    run_stream(3);
  endtask

  task automatic test_edges();
    txq.push_back(txn_t'{tb: 4'd8, ta: 4'd1, mask: 2'b11});
    txq.push_back(txn_t'{tb: 4'd5, ta: 4'd0, mask: 2'b11});
    txq.push_back(txn_t'{tb: 4'd9, ta: 4'd3, mask: 2'b11});
    txq.push_back(txn_t'{tb: 4'd7, ta: 4'd15, mask: 2'b10});
    run_stream(5);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      txn_t x;
      x.ta   = 4'($urandom_range(0, 15));
      x.tb   = 4'($urandom_range(0, 15));
      x.mask = 2'($urandom_range(0, 3));
      txq.push_back(x);
    end
    run_stream(9);
  endtask

  task automatic test_en_drop();
    txn_t a;
    txn_t b;
    a = txn_t'{tb: 4'd4, ta: 4'd2, mask: 2'b11};
    b = txn_t'{tb: 4'd3, ta: 4'd6, mask: 2'b01};
    present(a);
    @(posedge aclk);
    #1;
    present(b);
    en = 1'b1;
    @(posedge aclk);
    for (int c = 0; c < G; c++) begin
      @(negedge aclk);
      n_chk += 2;
      if (spike_o !== exp_spk(a, c)) begin
        n_fail++;
        $display("FAIL drop_spike k=%0d got %b want %b", c, spike_o, exp_spk(a, c));
      end
      if (busy_o !== 1'b1) begin
        n_fail++;
        $display("FAIL drop_busy k=%0d got %b want 1", c, busy_o);
      end
      if (c == 1) in_valid = 1'b0;
      if (c == 5) en = 1'b0;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge aclk);
      n_chk++;
      if ({busy_o, spike_o, gamma_rst_o, underrun_o, in_ready} !== 6'b0) begin
        n_fail++;
        $display("FAIL drop_idle c=%0d got %b want 000000", c, {busy_o, spike_o, gamma_rst_o, underrun_o, in_ready});
      end
    end
    en = 1'b1;
    for (int c = 0; c < G; c++) begin
      @(negedge aclk);
      n_chk += 3;
      if (spike_o !== exp_spk(b, c)) begin
        n_fail++;
        $display("FAIL resume_spike k=%0d got %b want %b", c, spike_o, exp_spk(b, c));
      end
      if ({gamma_rst_o, underrun_o} !== {c == 0, 1'b0}) begin
        n_fail++;
        $display("FAIL resume_gamma k=%0d got %b want %b", c, {gamma_rst_o, underrun_o}, {c == 0, 1'b0});
      end
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL resume_in_ready k=%0d got %b want 1", c, in_ready);
      end
      if (c == G - 1) en = 1'b0;
    end
    @(negedge aclk);
    n_chk++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL resume_end_busy got %b want 0", busy_o);
    end
  endtask

  task automatic test_reset_mid();
    txn_t a;
    txn_t b;
    a = txn_t'{tb: 4'd4, ta: 4'd2, mask: 2'b11};
    b = txn_t'{tb: 4'd5, ta: 4'd5, mask: 2'b11};
    present(a);
    @(posedge aclk);
    #1;
    present(b);
    en = 1'b1;
    @(posedge aclk);
    for (int c = 0; c <= 6; c++) begin
      @(negedge aclk);
      if (c == 1) in_valid = 1'b0;
    end
    n_chk++;
    if (spike_o !== exp_spk(a, 6)) begin
      n_fail++;
      $display("FAIL midrst_pre_spike got %b want %b", spike_o, exp_spk(a, 6));
    end
    #1;
    grst_n = 1'b0;
    en = 1'b0;
    #1;
    n_chk += 2;
    if ({spike_o, gamma_rst_o, busy_o, underrun_o, range_err_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs got %b want 000000", {spike_o, gamma_rst_o, busy_o, underrun_o, range_err_o});
    end
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_in_ready got %b want 1", in_ready);
    end
    @(negedge aclk);
    grst_n = 1'b1;
    run_stream(1);
  endtask

  initial begin
    test_reset();
    test_underrun();
    test_pair();
    test_back_to_back();
    test_edges();
    test_random();
    test_en_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
